// File: rtl/accel_spi_pkg.sv
// Shared types and constants for the ADXL362 SPI sequencer.
package accel_spi_pkg;

   typedef enum logic [2:0] {
      CFG_START,
      CFG_XFER,
      CFG_GAP,
      IDLE,
      RD_XFER,
      RD_DONE,
      WAIT
   } state_e;

   localparam logic [7:0] CMD_WR      = 8'h0A;
   localparam logic [7:0] CMD_RD      = 8'h0B;
   localparam logic [7:0] REG_XDATA_L = 8'h0E;

   localparam int CFG_LEN = 3;
   localparam int RD_LEN  = 8;

   // Byte to shift out at position idx of a config or read frame.
   function automatic logic [7:0] frame_byte(input logic       is_cfg,
                                             input logic [2:0] idx,
                                             input logic [7:0] cfg_reg,
                                             input logic [7:0] cfg_val);
      logic [7:0] b;
      b = 8'h00;
      if (is_cfg) begin
         case (idx)
            3'd0:    b = CMD_WR;
            3'd1:    b = cfg_reg;
            3'd2:    b = cfg_val;
            default: b = 8'h00;
         endcase
      end else begin
         case (idx)
            3'd0:    b = CMD_RD;
            3'd1:    b = REG_XDATA_L;
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter. A byte starts with a CLK_DIV-cycle low phase;
// o_done is asserted combinationally in the last cycle of bit 7's high
// phase so the caller can chain the next byte with no gap on SCLK.
module spi_byte_engine #(
   parameter int CLK_DIV = 25
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_tx_byte,
   output logic [7:0] o_rx_byte,
   output logic       o_done,
   output logic       o_sclk,
   output logic       o_mosi,
   input  logic       i_miso
);

   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

   logic          busy_q, busy_d;
   logic          sclk_q, sclk_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [2:0]    bit_q,  bit_d;
   logic [7:0]    tx_q,   tx_d;
   logic [7:0]    rx_q,   rx_d;
   logic          half_end;
   logic          load;

   assign half_end  = busy_q && (hcnt_q == HALF_LAST);
   assign o_done    = half_end && sclk_q && (bit_q == 3'd7);
   assign o_rx_byte = rx_q;
   assign o_sclk    = sclk_q;
   assign o_mosi    = tx_q[7];

   // Half-period timing, MISO capture on the rising toggle, MOSI shift on the falling one.
   always_comb begin
      busy_d = busy_q;
      sclk_d = sclk_q;
      hcnt_d = hcnt_q;
      bit_d  = bit_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      load   = 1'b0;
      if (busy_q) begin
         hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
         if (half_end) begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
               rx_d   = {rx_q[6:0], i_miso};
            end else begin
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  if (i_start) begin
                     load = 1'b1;
                  end else begin
                     busy_d = 1'b0;
                     tx_d   = '0;     // MOSI parks low between frames
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = {tx_q[6:0], 1'b0};
               end
            end
         end
      end else if (i_start) begin
         load = 1'b1;
      end
      if (load) begin
         busy_d = 1'b1;
         hcnt_d = '0;
         bit_d  = '0;
         tx_d   = i_tx_byte;
      end
   end

   // State registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_q <= 1'b0;
         sclk_q <= 1'b0;
         hcnt_q <= '0;
         bit_q  <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
      end else begin
         busy_q <= busy_d;
         sclk_q <= sclk_d;
         hcnt_q <= hcnt_d;
         bit_q  <= bit_d;
         tx_q   <= tx_d;
         rx_q   <= rx_d;
      end
   end

endmodule

// File: rtl/accel_spi_sequencer.sv
// ADXL362 sequencer: one config write after reset, then periodic X/Y/Z
// burst reads published on registered outputs with a one-cycle o_valid.
module accel_spi_sequencer
   import accel_spi_pkg::*;
#(
   parameter int         CLK_DIV       = 25,
   parameter int         SAMPLE_PERIOD = 500000,
   parameter logic [7:0] CFG_REG       = 8'h2D,
   parameter logic [7:0] CFG_VAL       = 8'h02
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   output logic        o_accel_sclk,
   output logic        o_accel_cs_n,
   output logic        o_accel_mosi,
   input  logic        i_accel_miso,
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic [15:0] o_z,
   output logic        o_valid,
   output logic        o_cfg_done,
   output logic        o_busy
);

   localparam int GAP = 2 * CLK_DIV;
   localparam int TW  = $clog2(GAP + 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
   localparam logic [TW-1:0] TMR_MAX   = TW'(GAP);
   localparam logic [TW-1:0] HOLD_LAST = TW'(CLK_DIV - 1);
   localparam logic [31:0]   PER_LAST  = 32'(SAMPLE_PERIOD - 1);

   state_e          state_q, state_d;
   logic            cs_n_q, cs_n_d;
   logic            busy_q, busy_d;
   logic            cfg_done_q, cfg_done_d;
   logic            valid_q, valid_d;
   logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
   logic [2:0]      idx_q, idx_d;
   logic            hold_q, hold_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [31:0]     per_q, per_d;
   logic [5:0][7:0] shadow_q, shadow_d;

   logic       eng_start;
   logic [7:0] eng_tx;
   logic [7:0] eng_rx;
   logic       eng_done;
   logic       gap_ok;
   logic       last_byte;
   logic       start_rd;

   // tmr_q counts CS_n-high time after a frame (saturating), or CS hold time.
   assign gap_ok    = (tmr_q >= GAP_LAST);
   assign last_byte = (state_q == CFG_XFER) ? (idx_q == 3'(CFG_LEN - 1))
                                            : (idx_q == 3'(RD_LEN - 1));

   spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (eng_start),
      .i_tx_byte (eng_tx),
      .o_rx_byte (eng_rx),
      .o_done    (eng_done),
      .o_sclk    (o_accel_sclk),
      .o_mosi    (o_accel_mosi),
      .i_miso    (i_accel_miso)
   );

   // Sequencer next-state: frame framing, byte chaining, sample period.
   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      cfg_done_d = cfg_done_q;
      valid_d    = 1'b0;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      shadow_d   = shadow_q;
      tmr_d      = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
      per_d      = (per_q == PER_LAST) ? per_q : per_q + 32'd1;
      eng_start  = 1'b0;
      eng_tx     = '0;
      start_rd   = 1'b0;

      case (state_q)
         // Also waits out the CS_n-high minimum after a mid-frame reset.
         CFG_START: begin
            if (gap_ok) begin
               state_d   = CFG_XFER;
               cs_n_d    = 1'b0;
               idx_d     = '0;
               hold_d    = 1'b0;
               eng_start = 1'b1;
               eng_tx    = frame_byte(1'b1, 3'd0, CFG_REG, CFG_VAL);
            end
         end
         CFG_XFER, RD_XFER: begin
            if (!hold_q) begin
               if (eng_done) begin
                  if (state_q == RD_XFER && idx_q >= 3'd2)
                     shadow_d[idx_q - 3'd2] = eng_rx;
                  if (last_byte) begin
                     hold_d = 1'b1;
                     tmr_d  = '0;
                  end else begin
                     idx_d     = idx_q + 3'd1;
                     eng_start = 1'b1;
                     eng_tx    = frame_byte(state_q == CFG_XFER, idx_q + 3'd1,
                                            CFG_REG, CFG_VAL);
                  end
               end
            end else if (tmr_q == HOLD_LAST) begin
               cs_n_d = 1'b1;
               hold_d = 1'b0;
               tmr_d  = '0;
               if (state_q == CFG_XFER) begin
                  cfg_done_d = 1'b1;
                  state_d    = CFG_GAP;
               end else begin
                  state_d = RD_DONE;
               end
            end
         end
         CFG_GAP: begin
            if (gap_ok) state_d = IDLE;
         end
         IDLE: begin
            if (i_enable && gap_ok) start_rd = 1'b1;
         end
         RD_DONE: begin
            x_d     = {shadow_q[1], shadow_q[0]};
            y_d     = {shadow_q[3], shadow_q[2]};
            z_d     = {shadow_q[5], shadow_q[4]};
            valid_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (!i_enable)                          state_d  = IDLE;
            else if (per_q == PER_LAST && gap_ok)   start_rd = 1'b1;
         end
         default: state_d = CFG_START;
      endcase

      if (start_rd) begin
         state_d   = RD_XFER;
         cs_n_d    = 1'b0;
         idx_d     = '0;
         hold_d    = 1'b0;
         per_d     = '0;
         eng_start = 1'b1;
         eng_tx    = frame_byte(1'b0, 3'd0, CFG_REG, CFG_VAL);
      end

      busy_d = !cs_n_d;
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= CFG_START;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         valid_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         idx_q      <= '0;
         hold_q     <= 1'b0;
         tmr_q      <= '0;
         per_q      <= '0;
         shadow_q   <= '0;
      end else begin
         state_q    <= state_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         cfg_done_q <= cfg_done_d;
         valid_q    <= valid_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         tmr_q      <= tmr_d;
         per_q      <= per_d;
         shadow_q   <= shadow_d;
      end
   end

   assign o_accel_cs_n = cs_n_q;
   assign o_busy       = busy_q;
   assign o_cfg_done   = cfg_done_q;
   assign o_valid      = valid_q;
   assign o_x          = x_q;
   assign o_y          = y_q;
   assign o_z          = z_q;

endmodule
